ndp_operand_loader: RTL

Feeder for the NDP compute unit. It accepts one command (SIMD mode) plus a stream of 4-lane operand beats from the memory side and assembles them into the wide operand buses: 1 beat for operand A, B_BEATS beats for operand B. It then presents A, B and the SIMD control to the unit with a one-cycle in_done_flag strobe, and holds them stable until the unit returns calc_done_flag. It sits between the memory/DMA stream and the NDP unit inside the NDP core.

---
 rtl/ndp_operand_loader.sv | 110 +++++++++++
 1 files changed

// File: rtl/ndp_operand_loader.sv
// Operand feeder for the NDP compute unit: takes one SIMD command, assembles operand A
// (one beat) and operand B (B_BEATS beats), issues them with a strobe and holds until done.
module ndp_operand_loader #(
    parameter int WIDTH   = 16,
    parameter int B_BEATS = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_simd,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [4*WIDTH-1:0]           s_data,
    output logic [4*WIDTH-1:0]           in_a,
    output logic [4*B_BEATS*WIDTH-1:0]   in_b,
    output logic [1:0]                   SIMD_Control,
    output logic                         in_done_flag,
    input  logic                         calc_done_flag,
    output logic                         busy,
    output logic [15:0]                  op_count
);

    localparam int BEAT_W = 4 * WIDTH;
    localparam int CNT_W  = (B_BEATS > 1) ? $clog2(B_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(B_BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ISSUE,
        WAIT_CALC
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             cmd_fire;
    logic             a_fire;
    logic             b_fire;
    logic             calc_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake readiness and the issue strobe are decoded straight from the registered state.
    always_comb begin
        state_nxt    = state;
        cmd_ready    = 1'b0;
        s_ready      = 1'b0;
        in_done_flag = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = LOAD_A;
            end
            LOAD_A: begin
                s_ready = 1'b1;
                if (s_valid) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                s_ready = 1'b1;
                if (s_valid && (beat_cnt == LAST_BEAT)) state_nxt = ISSUE;
            end
            ISSUE: begin
                in_done_flag = 1'b1;
                state_nxt    = WAIT_CALC;
            end
            WAIT_CALC: begin
                if (calc_done_flag) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_fire  = (state == IDLE)   && cmd_valid;
    assign a_fire    = (state == LOAD_A) && s_valid;
    assign b_fire    = (state == LOAD_B) && s_valid;
    assign calc_fire = (state == WAIT_CALC) && calc_done_flag;
    assign busy      = (state != IDLE);

    // Operand registers only change on accepted beats, so they hold through ISSUE and WAIT_CALC.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_a         <= '0;
            in_b         <= '0;
            SIMD_Control <= '0;
            beat_cnt     <= '0;
            op_count     <= '0;
        end else begin
            if (cmd_fire) begin
                SIMD_Control <= cmd_simd;
                beat_cnt     <= '0;
            end
            if (a_fire) in_a <= s_data;
            if (b_fire) begin
                in_b[int'(beat_cnt) * BEAT_W +: BEAT_W] <= s_data;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (calc_fire) op_count <= op_count + 16'd1;
        end
    end

endmodule
